// File: rtl/rf_wport_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter.
// Widths, reset words and the default aging limit live here.
package rf_wport_arbiter_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned REG_BUS = 5;
  localparam int unsigned WAIT_W  = 4;

  localparam int unsigned MAX_WAIT_DEFAULT = 4;

  localparam logic [XLEN-1:0]    ZERO_WORD = '0;
  localparam logic [REG_BUS-1:0] REG_X0    = '0;

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Bundles the pipeline write-back, long-latency handshake and regfile write port.
// master = the sources/regfile side, slave = the arbiter.
interface rf_wport_arbiter_if;
  import rf_wport_arbiter_pkg::*;

  logic               p_ena;
  logic [REG_BUS-1:0] p_addr;
  logic [XLEN-1:0]    p_data;
  logic               p_stall;

  logic               l_valid;
  logic               l_ready;
  logic [REG_BUS-1:0] l_addr;
  logic [XLEN-1:0]    l_data;

  logic               rf_wena;
  logic [REG_BUS-1:0] rf_waddr;
  logic [XLEN-1:0]    rf_wdata;

  modport master (
    output p_ena, p_addr, p_data, l_valid, l_addr, l_data,
    input  p_stall, l_ready, rf_wena, rf_waddr, rf_wdata
  );

  modport slave (
    input  p_ena, p_addr, p_data, l_valid, l_addr, l_data,
    output p_stall, l_ready, rf_wena, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/rf_wport_arbiter_wb_lbuf.sv
// Two-entry FIFO holding long-latency results until they win the write port.
// The caller never pushes when full or pops when empty.
module wb_lbuf
  import rf_wport_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [REG_BUS-1:0] push_addr,
  input  logic [XLEN-1:0]    push_data,
  input  logic               pop,
  output logic [1:0]         count,
  output logic               head_valid,
  output logic [REG_BUS-1:0] head_addr,
  output logic [XLEN-1:0]    head_data
);

  logic [REG_BUS-1:0] addr_q [2];
  logic [XLEN-1:0]    data_q [2];
  logic               rd_ptr;
  logic               wr_ptr;

  // Storage is not reset; only the pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= push_addr;
        data_q[wr_ptr] <= push_data;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != 2'd0);
  assign head_addr  = addr_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];

endmodule

// File: rtl/rf_wport_arbiter.sv
// Pipeline-first arbitration of the single regfile write port, with an aging
// counter that forces a buffered long-latency result through after MAX_WAIT losses.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  rf_wport_arbiter_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic               p_req;
  logic               grant_l;
  logic               grant_p;
  logic               lbuf_push;
  logic [1:0]         lbuf_count;
  logic               head_valid;
  logic [REG_BUS-1:0] head_addr;
  logic [XLEN-1:0]    head_data;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               rf_wena_q;
  logic [REG_BUS-1:0] rf_waddr_q;
  logic [XLEN-1:0]    rf_wdata_q;

  assign p_req   = bus.p_ena && (bus.p_addr != REG_X0);
  assign grant_l = !rst && head_valid && (!p_req || (wait_cnt >= WAIT_LIMIT));
  assign grant_p = !rst && p_req && !grant_l;

  // l_ready looks only at the registered count, so a full buffer reopens one cycle after its pop.
  assign bus.l_ready = !rst && (lbuf_count != 2'd2);
  assign bus.p_stall = p_req && grant_l;
  assign lbuf_push   = bus.l_valid && bus.l_ready && (bus.l_addr != REG_X0);

  wb_lbuf u_lbuf (
    .clk        (clk),
    .rst        (rst),
    .push       (lbuf_push),
    .push_addr  (bus.l_addr),
    .push_data  (bus.l_data),
    .pop        (grant_l),
    .count      (lbuf_count),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_data  (head_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (grant_l || !head_valid) begin
      wait_cnt <= '0;
    end else if (wait_cnt < WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Address/data hold their last value on idle cycles; only the enable drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wena_q  <= 1'b0;
      rf_waddr_q <= REG_X0;
      rf_wdata_q <= ZERO_WORD;
    end else begin
      rf_wena_q <= grant_l || grant_p;
      if (grant_l) begin
        rf_waddr_q <= head_addr;
        rf_wdata_q <= head_data;
      end else if (grant_p) begin
        rf_waddr_q <= bus.p_addr;
        rf_wdata_q <= bus.p_data;
      end
    end
  end

  assign bus.rf_wena  = rf_wena_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter with MAX_WAIT=4; one task per scenario.
module tb_rf_wport_arbiter;
  import rf_wport_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rf_wport_arbiter_if bus ();

  rf_wport_arbiter #(.MAX_WAIT(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.p_ena   = 1'b0;
    bus.p_addr  = '0;
    bus.p_data  = '0;
    bus.l_valid = 1'b0;
    bus.l_addr  = '0;
    bus.l_data  = '0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.p_ena   = 1'b1;
    bus.p_addr  = 5'd3;
    bus.p_data  = 64'h33;
    bus.l_valid = 1'b1;
    bus.l_addr  = 5'd4;
    bus.l_data  = 64'h44;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (bus.rf_wena !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_wena cyc=%0d got=%b exp=0", i, bus.rf_wena);
      end
      total++;
      if (bus.l_ready !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_lready cyc=%0d got=%b exp=0", i, bus.l_ready);
      end
      total++;
      if (bus.p_stall !== 1'b0) begin
        bad++; $display("[TB] FAIL reset_pstall cyc=%0d got=%b exp=0", i, bus.p_stall);
      end
    end
    total++;
    if ({bus.rf_waddr, bus.rf_wdata} !== {5'd0, 64'd0}) begin
      bad++; $display("[TB] FAIL reset_wport got=%h/%h exp=0/0", bus.rf_waddr, bus.rf_wdata);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    total++;
    if (bus.l_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL post_reset_lready got=%b exp=1", bus.l_ready);
    end
    total++;
    if (bus.rf_wena !== 1'b0) begin
      bad++; $display("[TB] FAIL post_reset_wena got=%b exp=0", bus.rf_wena);
    end
  endtask

  task automatic test_pipeline();
    bus.p_ena  = 1'b1;
    bus.p_addr = 5'd5;
    bus.p_data = 64'hAA;
    #1;
    total++;
    if (bus.p_stall !== 1'b0) begin
      bad++; $display("[TB] FAIL pipe_stall got=%b exp=0", bus.p_stall);
    end
    tick();
    total++;
    if ({bus.rf_wena, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 64'hAA}) begin
      bad++; $display("[TB] FAIL pipe_write got=%b/%0d/%h exp=1/5/aa", bus.rf_wena, bus.rf_waddr, bus.rf_wdata);
    end
    bus.p_addr = 5'd0;
    bus.p_data = 64'hBB;
    #1;
    total++;
    if (bus.p_stall !== 1'b0) begin
      bad++; $display("[TB] FAIL pipe_x0_stall got=%b exp=0", bus.p_stall);
    end
    tick();
    total++;
    if ({bus.rf_wena, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 5'd5, 64'hAA}) begin
      bad++; $display("[TB] FAIL pipe_x0_write got=%b/%0d/%h exp=0/5/aa", bus.rf_wena, bus.rf_waddr, bus.rf_wdata);
    end
    idle_inputs();
  endtask

  task automatic test_long_only();
    bus.l_valid = 1'b1;
    bus.l_addr  = 5'd7;
    bus.l_data  = 64'h11;
    #1;
    total++;
    if (bus.l_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL long_ready got=%b exp=1", bus.l_ready);
    end
    tick();
    bus.l_addr = 5'd8;
    bus.l_data = 64'h22;
    total++;
    if (bus.rf_wena !== 1'b0) begin
      bad++; $display("[TB] FAIL long_n1_wena got=%b exp=0", bus.rf_wena);
    end
    tick();
    bus.l_valid = 1'b0;
    total++;
    if ({bus.rf_wena, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd7, 64'h11}) begin
      bad++; $display("[TB] FAIL long_first got=%b/%0d/%h exp=1/7/11", bus.rf_wena, bus.rf_waddr, bus.rf_wdata);
    end
    tick();
    total++;
    if ({bus.rf_wena, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd8, 64'h22}) begin
      bad++; $display("[TB] FAIL long_second got=%b/%0d/%h exp=1/8/22", bus.rf_wena, bus.rf_waddr, bus.rf_wdata);
    end
    tick();
    total++;
    if (bus.rf_wena !== 1'b0) begin
      bad++; $display("[TB] FAIL long_drained got=%b exp=0", bus.rf_wena);
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    bus.p_ena   = 1'b1;
    bus.p_addr  = 5'd9;
    bus.p_data  = 64'h99;
    bus.l_valid = 1'b1;
    bus.l_addr  = 5'd10;
    bus.l_data  = 64'h1010;
    tick();
    bus.l_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (bus.p_stall !== 1'b0) begin
        bad++; $display("[TB] FAIL starve_lose%0d_stall got=%b exp=0", i, bus.p_stall);
      end
      tick();
      total++;
      if ({bus.rf_wena, bus.rf_waddr} !== {1'b1, 5'd9}) begin
        bad++; $display("[TB] FAIL starve_lose%0d_write got=%b/%0d exp=1/9", i, bus.rf_wena, bus.rf_waddr);
      end
    end
    #1;
    total++;
    if (bus.p_stall !== 1'b1) begin
      bad++; $display("[TB] FAIL starve_grant_stall got=%b exp=1", bus.p_stall);
    end
    tick();
    total++;
    if ({bus.rf_wena, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd10, 64'h1010}) begin
      bad++; $display("[TB] FAIL starve_l_write got=%b/%0d/%h exp=1/10/1010", bus.rf_wena, bus.rf_waddr, bus.rf_wdata);
    end
    total++;
    if (bus.p_stall !== 1'b0) begin
      bad++; $display("[TB] FAIL starve_after_stall got=%b exp=0", bus.p_stall);
    end
    tick();
    total++;
    if ({bus.rf_wena, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd9, 64'h99}) begin
      bad++; $display("[TB] FAIL starve_p_write got=%b/%0d/%h exp=1/9/99", bus.rf_wena, bus.rf_waddr, bus.rf_wdata);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_full_buffer();
    bus.p_ena   = 1'b1;
    bus.p_addr  = 5'd12;
    bus.p_data  = 64'hC;
    bus.l_valid = 1'b1;
    bus.l_addr  = 5'd1;
    bus.l_data  = 64'h101;
    tick();
    bus.l_addr = 5'd2;
    bus.l_data = 64'h202;
    tick();
    bus.l_addr = 5'd3;
    bus.l_data = 64'h303;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (bus.l_ready !== 1'b0) begin
        bad++; $display("[TB] FAIL full_ready%0d got=%b exp=0", i, bus.l_ready);
      end
      total++;
      if (bus.p_stall !== (i == 3)) begin
        bad++; $display("[TB] FAIL full_stall%0d got=%b exp=%b", i, bus.p_stall, (i == 3));
      end
      tick();
    end
    total++;
    if (bus.l_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL full_reopen got=%b exp=1", bus.l_ready);
    end
    total++;
    if ({bus.rf_wena, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd1, 64'h101}) begin
      bad++; $display("[TB] FAIL full_first got=%b/%0d/%h exp=1/1/101", bus.rf_wena, bus.rf_waddr, bus.rf_wdata);
    end
    tick();
    bus.l_valid = 1'b0;
    bus.p_ena   = 1'b0;
    total++;
    if ({bus.rf_wena, bus.rf_waddr} !== {1'b1, 5'd12}) begin
      bad++; $display("[TB] FAIL full_pipe got=%b/%0d exp=1/12", bus.rf_wena, bus.rf_waddr);
    end
    tick();
    total++;
    if ({bus.rf_wena, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd2, 64'h202}) begin
      bad++; $display("[TB] FAIL full_second got=%b/%0d/%h exp=1/2/202", bus.rf_wena, bus.rf_waddr, bus.rf_wdata);
    end
    tick();
    total++;
    if ({bus.rf_wena, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd3, 64'h303}) begin
      bad++; $display("[TB] FAIL full_third got=%b/%0d/%h exp=1/3/303", bus.rf_wena, bus.rf_waddr, bus.rf_wdata);
    end
    tick();
    total++;
    if (bus.rf_wena !== 1'b0) begin
      bad++; $display("[TB] FAIL full_drained got=%b exp=0", bus.rf_wena);
    end
    idle_inputs();
  endtask

  task automatic test_x0_and_reset();
    bus.l_valid = 1'b1;
    bus.l_addr  = 5'd0;
    bus.l_data  = 64'hDEAD;
    #1;
    total++;
    if (bus.l_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL x0_ready got=%b exp=1", bus.l_ready);
    end
    tick();
    bus.l_valid = 1'b0;
    total++;
    if (u_dut.lbuf_count !== 2'd0) begin
      bad++; $display("[TB] FAIL x0_count got=%0d exp=0", u_dut.lbuf_count);
    end
    tick();
    total++;
    if (bus.rf_wena !== 1'b0) begin
      bad++; $display("[TB] FAIL x0_no_write got=%b exp=0", bus.rf_wena);
    end
    bus.p_ena   = 1'b1;
    bus.p_addr  = 5'd13;
    bus.p_data  = 64'hD;
    bus.l_valid = 1'b1;
    bus.l_addr  = 5'd20;
    bus.l_data  = 64'h2020;
    tick();
    bus.l_addr = 5'd21;
    bus.l_data = 64'h2121;
    tick();
    total++;
    if (u_dut.lbuf_count !== 2'd2) begin
      bad++; $display("[TB] FAIL midrst_fill got=%0d exp=2", u_dut.lbuf_count);
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (u_dut.lbuf_count !== 2'd0) begin
      bad++; $display("[TB] FAIL midrst_count got=%0d exp=0", u_dut.lbuf_count);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (bus.rf_wena !== 1'b0) begin
        bad++; $display("[TB] FAIL midrst_ghost%0d got=%b/%0d exp=0", i, bus.rf_wena, bus.rf_waddr);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_pipeline();
    test_long_only();
    test_starvation();
    test_full_buffer();
    test_x0_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the single register-file write port between the in-order pipeline write-back path and a long-latency unit, e.g. multiply/divide or a non-blocking load return. The long-latency unit gets a 2-entry buffer. Arbitration is pipeline-first with an aging override, so buffered results cannot starve. The block sits between the write-back stage outputs and the regfile write port, and drives a stall back to the pipeline when it loses arbitration.

## Interface
- XLEN, 64, data width of a register
- MAX_WAIT, 4, cycles a buffered result may lose before it takes priority (1..15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset rst, synchronous, active-high
- p_ena  in  1  pipeline write-back request
- p_addr  in  5  pipeline destination register
- p_data  in  XLEN  pipeline write data
- p_stall  out  1  pipeline request not granted this cycle; pipeline holds p_* stable
- l_valid  in  1  long-latency result offered
- l_ready  out  1  buffer can accept; transfer when l_valid && l_ready
- l_addr  in  5  long-latency destination register
- l_data  in  XLEN  long-latency result
- rf_wena  out  1  registered regfile write enable
- rf_waddr  out  5  registered regfile write address
- rf_wdata  out  XLEN  registered regfile write data

## Operation
- Effective pipeline request: p_req = p_ena && (p_addr != 0). x0 writes are ignored and never stall.
- Buffer: 2-entry FIFO of {addr, data}, with a registered count of 0..2.
  - l_ready = (count < 2). It is computed from the registered count only, with no pass-through of a same-cycle pop.
  - An accepted entry with l_addr == 0 is consumed (the handshake completes) but not stored.
- Grant, evaluated each cycle on the current head:
  - grant_L = head valid && (!p_req || wait_cnt >= MAX_WAIT).
  - grant_P = p_req && !grant_L.
- p_stall = p_req && grant_L. It is combinational.
- Pop: the head pops on grant_L. Enqueue and pop may occur in the same cycle, and count is updated by both.
- wait_cnt (4 bits):
  - cleared on pop, and while the buffer is empty;
  - otherwise incremented when the head is valid and not granted;
  - saturates at MAX_WAIT.
- Write port register: on the next edge,
  - rf_wena <= grant_L || grant_P;
  - rf_waddr and rf_wdata take the granted source;
  - when nothing is granted, rf_wena <= 0 and rf_waddr/rf_wdata hold their previous values.
- Ordering:
  - Long-latency results retire in FIFO order.
  - No ordering is enforced between P and L. The issue-side scoreboard guarantees they never target the same register while both are in flight.

## Timing
- Reset, while rst is high:
  - rf_wena=0, rf_waddr=0, rf_wdata=0;
  - count=0, wait_cnt=0;
  - l_ready=0 and p_stall=0.
- A reset mid-operation discards all buffered entries. Those results are lost, and the pipeline is flushed by the same reset.
- Pipeline latency: granted in cycle N gives rf_wena=1 in cycle N+1.
- Long-latency latency:
  - An entry accepted in cycle N is not grantable in N, because it is not yet in the buffer.
  - Earliest grant is N+1, so earliest rf_wena is N+2.
- With continuous p_req, a buffered head is granted at most MAX_WAIT+1 cycles after it becomes head.
- Full buffer with a pop in cycle N: l_ready is still 0 in N and rises in N+1.
- A pop from a full buffer with a simultaneous enqueue cannot occur, because l_ready=0 while full.
- Empty buffer and no p_req: rf_wena=0 next cycle and p_stall=0.

## Structure
- Shared package/defines:
  - XLEN and the REG_BUS width;
  - ZERO_WORD;
  - the default MAX_WAIT;
  - the x0 index constant.
- Sub-module wb_lbuf: a 2-entry FIFO with push/pop/count/head outputs and synchronous reset.
- The arbiter, the aging counter and the write-port register stay in the top level.

## Test plan
- Reset: drive rst for 2 cycles with p_ena=1 and l_valid=1.
  - Required: rf_wena=0, l_ready=0, p_stall=0 throughout.
  - Required: one cycle after rst falls, l_ready=1.
- Pipeline only: p_ena=1, p_addr=5, p_data=0xAA in cycle N.
  - Required: cycle N+1 shows rf_wena=1, rf_waddr=5, rf_wdata=0xAA, and p_stall stays 0.
  - Then p_addr=0 gives rf_wena=0 and p_stall=0.
- Long-latency only: accept l_addr=7, l_data=0x11 in cycle N, then l_addr=8 in N+1.
  - Required: writes appear at N+2 (reg 7) and N+3 (reg 8) in order.
- Starvation with MAX_WAIT=4: p_req held continuously and one entry buffered.
  - Required: the entry loses 4 cycles, is granted on the 5th, and p_stall=1 in exactly that cycle.
  - Required: the pipeline write lands the cycle after.
- Full buffer: fill 2 entries while p_req is held.
  - Required: l_ready=0 and l_valid is held.
  - Required: the cycle after the first pop, l_ready=1 and the third entry is accepted; FIFO order is preserved.
- x0 and reset mid-op:
  - An l entry with l_addr=0 is accepted and count is unchanged.
  - With 2 entries buffered, assert rst: count=0 and no rf write of the old entries ever appears.
